// File: rtl/fetch_stage_pkg.sv
// Shared types for the instruction-fetch stage: bus word types, fetch FSM
// states and the {pc, instruction} bundle handed to decode.
package fetch_stage_pkg;

  typedef logic [63:0] u64;
  typedef logic [31:0] u32;
  typedef u64          word_t;

  localparam u64 PC_RESET = 64'h8000_0000;

  typedef enum logic [1:0] {
    FETCH   = 2'd0,
    WAIT    = 2'd1,
    HOLD    = 2'd2,
    DISCARD = 2'd3
  } fetch_state_t;

  typedef struct packed {
    u32 raw_instr;
  } fetch_data_t;

  typedef struct packed {
    u64          pc;
    fetch_data_t data;
  } fetch_out_t;

endpackage

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, keeps one bus read outstanding at most,
// buffers the returned word for decode and handles redirects/squashes.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter u64 RESET_PC = PC_RESET,
  parameter int PC_STEP  = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        ireq_valid,
  output logic [63:0] ireq_addr,
  input  logic        iresp_addr_ok,
  input  logic        iresp_data_ok,
  input  logic [31:0] iresp_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_pc,
  output logic [31:0] out_data,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc
);

  fetch_state_t state, state_nxt;
  u64           pc, pc_nxt;
  fetch_out_t   out_q;
  logic         acc, capture;

  always_comb begin
    acc       = ireq_valid & iresp_addr_ok;
    state_nxt = state;
    pc_nxt    = pc;
    capture   = 1'b0;
    case (state)
      FETCH: begin
        if (acc && iresp_data_ok) begin
          if (!redirect_valid) begin
            state_nxt = HOLD;
            capture   = 1'b1;
          end
        end else if (acc) begin
          state_nxt = redirect_valid ? DISCARD : WAIT;
        end
      end
      WAIT: begin
        if (iresp_data_ok) begin
          state_nxt = redirect_valid ? FETCH : HOLD;
          capture   = ~redirect_valid;
        end else if (redirect_valid) begin
          state_nxt = DISCARD;
        end
      end
      HOLD: begin
        // a coincident handshake is void: decode is flushed by the same redirect
        if (redirect_valid) begin
          state_nxt = FETCH;
        end else if (out_ready) begin
          state_nxt = FETCH;
          pc_nxt    = pc + u64'(PC_STEP);
        end
      end
      DISCARD: begin
        if (iresp_data_ok) state_nxt = FETCH;
      end
      default: state_nxt = FETCH;
    endcase
    if (redirect_valid) pc_nxt = redirect_pc & ~64'h3;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= FETCH;
      pc         <= RESET_PC;
      ireq_valid <= 1'b0;
      out_valid  <= 1'b0;
      out_q      <= '0;
    end else begin
      state      <= state_nxt;
      pc         <= pc_nxt;
      ireq_valid <= (state_nxt == FETCH);
      out_valid  <= (state_nxt == HOLD);
      if (capture) begin
        out_q.pc             <= pc;
        out_q.data.raw_instr <= iresp_data;
      end
    end
  end

  assign ireq_addr = pc;
  assign out_pc    = out_q.pc;
  assign out_data  = out_q.data.raw_instr;

endmodule
